// File: rtl/kv_key_hasher.sv
// Streams a key in 32-bit LE beats through CRC-32 (poly 04C11DB7), folds in the byte length,
// and emits hash/length/bucket index. Define KV_HASH_FINAL_XOR_EN for a final-inverted hash.
module kv_key_hasher #(
    parameter int unsigned IDX_W         = 16,
    parameter int unsigned MAX_KEY_BYTES = 250
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic [3:0]       s_keep,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_hash,
    output logic [15:0]      m_len,
    output logic [IDX_W-1:0] m_idx,
    output logic             m_err
);

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        S_BODY,
        S_LEN,
        S_OUT
    } state_t;

    state_t      state;
    logic [31:0] crc;
    logic [15:0] len;

    logic [31:0] masked;
    logic [2:0]  keep_cnt;
    logic [16:0] len_sum;
    logic [15:0] len_add;
    logic [31:0] crc_in;
    logic [31:0] crc_nxt;
    logic [31:0] hash_fin;
    logic        accept;

    // MSB-first, 32 data bits per update
    function automatic logic [31:0] crc32_next(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int unsigned i = 0; i < 32; i++) begin
            fb = r[31] ^ d[5'(31 - i)];
            r  = {r[30:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
        return r;
    endfunction

    assign accept = s_valid & s_ready;

    always_comb begin
        masked   = '0;
        keep_cnt = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            masked[8*b +: 8] = s_keep[b] ? s_data[8*b +: 8] : 8'h00;
            keep_cnt         = keep_cnt + {2'b00, s_keep[b]};
        end
        len_sum = {1'b0, len} + {14'b0, keep_cnt};
        len_add = len_sum[16] ? 16'hFFFF : len_sum[15:0];
        crc_in  = (state == S_LEN) ? {16'h0000, len} : masked;
        crc_nxt = crc32_next(crc, crc_in);
    end

`ifdef KV_HASH_FINAL_XOR_EN
    assign hash_fin = ~crc_nxt;
`else
    assign hash_fin = crc_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_BODY;
            crc     <= CRC_INIT;
            len     <= '0;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            m_hash  <= '0;
            m_len   <= '0;
            m_idx   <= '0;
            m_err   <= 1'b0;
        end else begin
            case (state)
                S_BODY: begin
                    if (accept) begin
                        crc <= crc_nxt;
                        len <= len_add;
                        if (s_last) begin
                            state   <= S_LEN;
                            s_ready <= 1'b0;
                        end
                    end
                end
                S_LEN: begin
                    crc     <= crc_nxt;
                    m_hash  <= hash_fin;
                    m_len   <= len;
                    m_idx   <= hash_fin[IDX_W-1:0];
                    m_err   <= ({16'h0000, len} > 32'(MAX_KEY_BYTES));
                    m_valid <= 1'b1;
                    state   <= S_OUT;
                end
                S_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        crc     <= CRC_INIT;
                        len     <= '0;
                        s_ready <= 1'b1;
                        state   <= S_BODY;
                    end
                end
                default: begin
                    state   <= S_BODY;
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kv_key_hasher.sv
// Scoreboard bench for kv_key_hasher: randomized keys checked against a polynomial-division CRC model.
module tb_kv_key_hasher;

    localparam int unsigned IDX_W    = 12;
    localparam int unsigned MAX_KEY  = 250;
    localparam logic [31:0] POLY     = 32'h04C11DB7;
    localparam logic [31:0] IDX_MASK = 32'((64'd1 << IDX_W) - 64'd1);

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [31:0]      s_data  = '0;
    logic [3:0]       s_keep  = '0;
    logic             s_last  = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [31:0]      m_hash;
    logic [15:0]      m_len;
    logic [IDX_W-1:0] m_idx;
    logic             m_err;

    kv_key_hasher #(
        .IDX_W(IDX_W),
        .MAX_KEY_BYTES(MAX_KEY)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_hash(m_hash), .m_len(m_len), .m_idx(m_idx), .m_err(m_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] hash;
        logic [15:0] len;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] kd[$];
    logic [3:0]  kk[$];
    int          checks = 0;
    int          errors = 0;
    bit          rand_ready = 0;
    bit          gaps = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic abort_run(input string name);
        chk(name, 32'd0, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "bench stopped early");
    endtask

    // Remainder of (c ^ d) * x^32 modulo the generator polynomial.
    function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] v;
        v = c ^ d;
        repeat (32) v = v[31] ? ((v << 1) ^ POLY) : (v << 1);
        return v;
    endfunction

    function automatic exp_t model_key();
        exp_t        e;
        logic [31:0] c;
        logic [31:0] m;
        int          n;
        c = 32'hFFFFFFFF;
        n = 0;
        foreach (kd[i]) begin
            m = 32'h0;
            for (int b = 0; b < 4; b++)
                if (kk[i][b]) m = m | (kd[i] & (32'hFF << (8 * b)));
            c = crc_word(c, m);
            n = n + $countones(kk[i]);
            if (n > 65535) n = 65535;
        end
        c = crc_word(c, 32'(n));
`ifdef KV_HASH_FINAL_XOR_EN
        c = ~c;
`endif
        e.hash = c;
        e.len  = 16'(n);
        e.err  = (n > int'(MAX_KEY));
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        bit rdy;
        n = 0;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        forever begin
            rdy = s_ready;
            tick();
            if (rdy) break;
            n++;
            if (n > 300) abort_run("beat_accept_timeout");
        end
        s_valid = 1'b0;
        s_data  = $urandom;
        s_keep  = 4'($urandom);
        s_last  = 1'($urandom);
    endtask

    task automatic send_key();
        sbq.push_back(model_key());
        foreach (kd[i]) send_beat(kd[i], kk[i], (i == kd.size() - 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        rand_ready = 0;
        m_ready    = 1'b1;
        while (sbq.size() != 0) begin
            tick();
            n++;
            if (n > 2000) abort_run("drain_timeout");
        end
        tick();
    endtask

    // Monitor: compares the presented result against the queue head every cycle it is valid.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && m_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_m_valid", 32'd1, 32'd0);
                end else begin
                    chk("m_hash", m_hash, sbq[0].hash);
                    chk("m_len", {16'h0, m_len}, {16'h0, sbq[0].len});
                    chk("m_idx", 32'(m_idx), sbq[0].hash & IDX_MASK);
                    chk("m_err", {31'h0, m_err}, {31'h0, sbq[0].err});
                    if (m_ready) void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        int nb;
        logic [3:0] tails[4];
        tails[0] = 4'h1; tails[1] = 4'h3; tails[2] = 4'h7; tails[3] = 4'hF;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", {31'h0, s_ready}, 32'd1);
        chk("rst_m_valid", {31'h0, m_valid}, 32'd0);
        chk("rst_m_hash", m_hash, 32'd0);
        chk("rst_m_len", {16'h0, m_len}, 32'd0);
        chk("rst_m_idx", 32'(m_idx), 32'd0);
        chk("rst_m_err", {31'h0, m_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // single beat "abcd": latency and s_ready low for two cycles
        kd = {32'h64636261}; kk = {4'hF};
        send_key();
        chk("lat_t1_s_ready", {31'h0, s_ready}, 32'd0);
        chk("lat_t1_m_valid", {31'h0, m_valid}, 32'd0);
        tick();
        chk("lat_t2_s_ready", {31'h0, s_ready}, 32'd0);
        chk("lat_t2_m_valid", {31'h0, m_valid}, 32'd1);
        tick();
        chk("lat_t3_s_ready", {31'h0, s_ready}, 32'd1);
        chk("lat_t3_m_valid", {31'h0, m_valid}, 32'd0);
        drain();

        // partial tail, with and without garbage in masked bytes
        kd = {32'h11223344, 32'hAABBCCDD}; kk = {4'hF, 4'h3};
        send_key();
        kd = {32'h11223344, 32'h0000CCDD};
        send_key();
        drain();

        // back-pressure then immediate next key
        m_ready = 1'b0;
        kd = {32'h01020304, 32'h05060708}; kk = {4'hF, 4'hF};
        send_key();
        n = 0;
        while (!m_valid) begin
            tick();
            n++;
            if (n > 20) abort_run("m_valid_timeout");
        end
        repeat (5) begin
            chk("bp_s_ready", {31'h0, s_ready}, 32'd0);
            chk("bp_m_valid", {31'h0, m_valid}, 32'd1);
            tick();
        end
        m_ready = 1'b1;
        tick();
        chk("bp_release_s_ready", {31'h0, s_ready}, 32'd1);
        kd = {32'hDEADBEEF}; kk = {4'h7};
        send_key();
        drain();

        // oversize (253 bytes) then exactly the limit (250 bytes)
        kd = {}; kk = {};
        for (int i = 0; i < 63; i++) begin kd.push_back($urandom); kk.push_back(4'hF); end
        kd.push_back($urandom); kk.push_back(4'h1);
        send_key();
        kd = {}; kk = {};
        for (int i = 0; i < 62; i++) begin kd.push_back($urandom); kk.push_back(4'hF); end
        kd.push_back($urandom); kk.push_back(4'h3);
        send_key();
        drain();

        // reset mid-key discards the partial key
        for (int i = 0; i < 3; i++) send_beat($urandom, 4'hF, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_s_ready", {31'h0, s_ready}, 32'd1);
        chk("midrst_m_valid", {31'h0, m_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        kd = {32'h64636261}; kk = {4'hF};
        send_key();
        drain();

        // empty key, then a stalled 5-beat key
        kd = {32'h5A5A5A5A}; kk = {4'h0};
        send_key();
        gaps = 1;
        kd = {32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 32'h13121110};
        kk = {4'hF, 4'hF, 4'hF, 4'hF, 4'h7};
        send_key();
        drain();

        // random keys with random gaps and back-pressure
        for (int k = 0; k < 24; k++) begin
            rand_ready = 1;
            gaps = 1;
            kd = {}; kk = {};
            nb = $urandom_range(1, 10);
            for (int i = 0; i < nb; i++) begin
                kd.push_back($urandom);
                kk.push_back((i == nb - 1) ? tails[$urandom_range(0, 3)] : 4'hF);
            end
            send_key();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
